seq_alu: RTL
============

Name: seq_alu

Overview:
- Execution stage directly upstream of the accumulator/register file.
- Consumes the accumulator value (res) and the selected register value, and produces the 16-bit write-data word that the register file latches into res.
- Single-cycle logic/arithmetic ops plus iterative shift and multiply ops behind a start/busy/done handshake.
- Also produces the comparison flag (comp) for the controller.

Parameters:
- WIDTH, 16, datapath width of operands and result.
- SHAMT_W, 4, width of the shift-amount field taken from reg_in[SHAMT_W-1:0].

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request to begin op; sampled only when busy=0.
- op  in  4  operation code (encodings in alu_pkg).
- acc_in  in  WIDTH  accumulator operand (res value).
- reg_in  in  WIDTH  register operand (selected register value).
- result  out  WIDTH  write data to register file; holds last completed value.
- busy  out  1  high while an iterative op is in progress.
- done  out  1  one-cycle pulse when result is updated.
- comp  out  1  comparison flag; updated only by CMP.
- ovf  out  1  carry/overflow of last ADD/SUB/MUL; cleared by other ops.

Behaviour:
- Reset (async, rst_n=0): result=0, busy=0, done=0, comp=0, ovf=0, FSM=IDLE, all internal operand/counter registers 0.
- FSM states: IDLE, ITER.
- Capture edge: rising clk with state=IDLE and start=1. acc_in, reg_in and op are latched; later changes on the inputs are ignored.
- Single-cycle ops (ADD, SUB, AND, OR, XOR, NOT acc, PASS reg, CMP):
  - result is written on the capture edge; done=1 for the following cycle; busy stays 0; state stays IDLE.
  - Back-to-back starts on consecutive cycles are accepted.
- ADD/SUB: wrap modulo 2^WIDTH; ovf = unsigned carry-out (ADD) or borrow (SUB).
- CMP: comp = (acc_in < reg_in) unsigned; result = acc_in unchanged; ovf=0.
- SHL/SHR (logical, zero fill), n = reg_in[SHAMT_W-1:0]:
  - n=0: single-cycle; result = acc_in.
  - n>0: state=ITER, busy=1 from the capture edge. One bit position per cycle. Final value written on the nth edge after capture; busy drops on that same edge; done=1 for the next cycle.
- MUL: unsigned shift-add, 16 iterations; result = low WIDTH bits; ovf = 1 if the high half is nonzero. Result written 16 edges after capture; busy=1 throughout; done pulses after the final edge.
- start while busy=1: ignored, not queued.
- Undefined op codes: treated as PASS.
- result holds between ops. This is required because the register file latches write data every clock.
- Async reset mid-ITER: aborts immediately to the reset values. No partial result is ever visible on result.
- done and busy are never high in the same cycle.

Optional Feature:
- Macro SEQ_ALU_SIGNED_EN.
- Defined: CMP uses a signed (two's-complement) compare; SHR is arithmetic (sign fill); ovf for ADD/SUB reports signed overflow.
- Undefined: all unsigned as specified above; the signed logic is absent from the netlist.

Decomposition:
- Package alu_pkg:
  - op code constants: ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOT=5, PASS=6, CMP=7, SHL=8, SHR=9, MUL=10;
  - FSM state typedef (IDLE, ITER);
  - WIDTH default.
- One sub-module, alu_iter_unit, is natural: it holds the shift/multiply working registers and the iteration counter, with load/step/last handshake to the top-level FSM.
- seq_alu keeps the combinational single-cycle ops, the FSM, and the output registers.

Test Plan:
- Reset: assert rst_n=0 mid-MUL (cycle 5) -> result=0, busy=0, done=0, comp=0 immediately; the next MUL runs from scratch.
- ADD 0xFFFF+0x0002 -> result=0x0001, ovf=1, done one cycle after capture, busy never high; SUB 0x0003-0x0005 -> 0xFFFE, ovf=1.
- CMP acc=0x8000, reg=0x0001 -> comp=0 unsigned (comp=1 with SEQ_ALU_SIGNED_EN), result=0x8000.
- SHL acc=0x0001 reg=0x0004 -> busy for 4 cycles, result=0x0010; start pulsed during busy is ignored; SHR with n=0 -> single-cycle, result=acc.
- MUL 0x0100×0x0100 -> after 16 busy cycles result=0x0000, ovf=1; MUL 0x00FF×0x0003 -> 0x02FD, ovf=0.
- Back-to-back: start on 3 consecutive cycles (AND, OR, XOR) -> 3 done pulses, results in order, no dropped op.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op codes, FSM states, default sizes.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package alu_pkg;

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_SHAMT_W = 4;

    // Op code encodings; anything not listed behaves as OP_PASS.
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOT  = 4'd5;
    localparam logic [3:0] OP_PASS = 4'd6;
    localparam logic [3:0] OP_CMP  = 4'd7;
    localparam logic [3:0] OP_SHL  = 4'd8;
    localparam logic [3:0] OP_SHR  = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ITER = 1'b1
    } state_t;

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative shift / shift-add multiply engine: working registers plus step counter.
// Latency: one bit position per i_step; o_last flags the step that produces the final value.
// Backpressure: none; advances only when the controller asserts i_step.
// Ports: i_load latches operands/op/count, i_step advances one iteration, o_last marks
//        the final step, o_result/o_ovf give the value that step produces.
// Build option: SEQ_ALU_SIGNED_EN makes SHR arithmetic (sign fill).
module alu_iter_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [CNT_W-1:0] i_cnt,
    output logic             o_last,
    output logic [WIDTH-1:0] o_result,
    output logic             o_ovf
);

    logic [3:0]         r_op;
    logic [2*WIDTH-1:0] r_prod;   // MUL: {partial high, multiplier low}; shifts use the low half
    logic [WIDTH-1:0]   r_mcand;
    logic [CNT_W-1:0]   r_cnt;

    logic [2*WIDTH-1:0] w_next;
    logic [WIDTH:0]     w_psum;
    logic               w_fill;

`ifdef SEQ_ALU_SIGNED_EN
    assign w_fill = r_prod[WIDTH-1];
`else
    assign w_fill = 1'b0;
`endif

    // Shift-add: conditionally add the multiplicand into the high half, then shift the
    // whole product right so the next multiplier bit lands in bit 0.
    assign w_psum = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, (r_prod[0] ? r_mcand : '0)};

    always_comb begin
        w_next = r_prod;
        case (r_op)
            OP_SHL:  w_next = {{WIDTH{1'b0}}, r_prod[WIDTH-2:0], 1'b0};
            OP_SHR:  w_next = {{WIDTH{1'b0}}, w_fill, r_prod[WIDTH-1:1]};
            OP_MUL:  w_next = {w_psum, r_prod[WIDTH-1:1]};
            default: w_next = r_prod;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op    <= '0;
            r_prod  <= '0;
            r_mcand <= '0;
            r_cnt   <= '0;
        end else if (i_load) begin
            r_op  <= i_op;
            r_cnt <= i_cnt;
            if (i_op == OP_MUL) begin
                r_prod  <= {{WIDTH{1'b0}}, i_b};
                r_mcand <= i_a;
            end else begin
                r_prod  <= {{WIDTH{1'b0}}, i_a};
                r_mcand <= '0;
            end
        end else if (i_step) begin
            r_prod <= w_next;
            r_cnt  <= r_cnt - 1'b1;
        end
    end

    assign o_last   = (r_cnt == CNT_W'(1));
    assign o_result = w_next[WIDTH-1:0];
    assign o_ovf    = (r_op == OP_MUL) && (|w_next[2*WIDTH-1:WIDTH]);

endmodule

// File: rtl/seq_alu.sv
// Execution-stage ALU: single-cycle logic/arith ops plus iterative SHL/SHR/MUL.
// Latency: single-cycle ops done 1 cycle after capture; SHL/SHR n+1, MUL 17 (busy meanwhile).
// Backpressure: start is ignored (not queued) while busy; result holds between ops.
// Ports: clk/rst_n, start+op+acc_in+reg_in request; result (write data), busy, done pulse,
//        comp (CMP flag), ovf (carry/borrow/overflow of last ADD/SUB/MUL).
// Build option: SEQ_ALU_SIGNED_EN -> signed CMP, arithmetic SHR, signed ADD/SUB overflow.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int SHAMT_W = DEF_SHAMT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] acc_in,
    input  logic [WIDTH-1:0] reg_in,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             comp,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_result, w_result_nxt;
    logic             r_done, w_done_nxt;
    logic             r_comp, w_comp_nxt;
    logic             r_ovf, w_ovf_nxt;

    logic             w_load, w_step, w_is_iter;
    logic             w_iter_last, w_iter_ovf;
    logic [WIDTH-1:0] w_iter_res;
    logic [CNT_W-1:0] w_iter_cnt;

    logic [WIDTH:0]   w_sum, w_diff;
    logic             w_add_v, w_sub_v, w_lt;

    assign w_sum  = {1'b0, acc_in} + {1'b0, reg_in};
    assign w_diff = {1'b0, acc_in} - {1'b0, reg_in};

`ifdef SEQ_ALU_SIGNED_EN
    assign w_add_v = (acc_in[WIDTH-1] == reg_in[WIDTH-1]) && (w_sum[WIDTH-1]  != acc_in[WIDTH-1]);
    assign w_sub_v = (acc_in[WIDTH-1] != reg_in[WIDTH-1]) && (w_diff[WIDTH-1] != acc_in[WIDTH-1]);
    assign w_lt    = $signed(acc_in) < $signed(reg_in);
`else
    assign w_add_v = w_sum[WIDTH];
    assign w_sub_v = w_diff[WIDTH];
    assign w_lt    = acc_in < reg_in;
`endif

    // Zero-distance shifts complete in one cycle like the logic ops.
    assign w_is_iter  = (op == OP_MUL) ||
                        (((op == OP_SHL) || (op == OP_SHR)) && (reg_in[SHAMT_W-1:0] != '0));
    assign w_iter_cnt = (op == OP_MUL) ? CNT_W'(WIDTH) : CNT_W'(reg_in[SHAMT_W-1:0]);

    alu_iter_unit #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_load),
        .i_step   (w_step),
        .i_op     (op),
        .i_a      (acc_in),
        .i_b      (reg_in),
        .i_cnt    (w_iter_cnt),
        .o_last   (w_iter_last),
        .o_result (w_iter_res),
        .o_ovf    (w_iter_ovf)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start && w_is_iter) w_state_nxt = ST_ITER;
            ST_ITER: if (w_iter_last)        w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs plus iter-unit controls
    always_comb begin
        w_result_nxt = r_result;
        w_ovf_nxt    = r_ovf;
        w_comp_nxt   = r_comp;
        w_done_nxt   = 1'b0;
        w_load       = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && w_is_iter) begin
                    w_load = 1'b1;
                end else if (start) begin
                    w_done_nxt = 1'b1;
                    w_ovf_nxt  = 1'b0;
                    case (op)
                        OP_ADD: begin w_result_nxt = w_sum[WIDTH-1:0];  w_ovf_nxt = w_add_v; end
                        OP_SUB: begin w_result_nxt = w_diff[WIDTH-1:0]; w_ovf_nxt = w_sub_v; end
                        OP_AND:  w_result_nxt = acc_in & reg_in;
                        OP_OR:   w_result_nxt = acc_in | reg_in;
                        OP_XOR:  w_result_nxt = acc_in ^ reg_in;
                        OP_NOT:  w_result_nxt = ~acc_in;
                        OP_CMP: begin w_result_nxt = acc_in; w_comp_nxt = w_lt; end
                        OP_SHL, OP_SHR: w_result_nxt = acc_in;
                        default: w_result_nxt = reg_in;
                    endcase
                end
            end
            ST_ITER: begin
                w_step = 1'b1;
                // Only the final step reaches result, so no partial value is ever visible.
                if (w_iter_last) begin
                    w_result_nxt = w_iter_res;
                    w_ovf_nxt    = w_iter_ovf;
                    w_done_nxt   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_done   <= 1'b0;
            r_comp   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_result <= w_result_nxt;
            r_done   <= w_done_nxt;
            r_comp   <= w_comp_nxt;
            r_ovf    <= w_ovf_nxt;
        end
    end

    assign result = r_result;
    assign done   = r_done;
    assign comp   = r_comp;
    assign ovf    = r_ovf;
    assign busy   = (r_state == ST_ITER);

endmodule
